emu_ram_scan_ctrl: RTL



---
 rtl/emu_scan_pkg.sv | 26 ++
 rtl/emu_scan_skid_fifo.sv | 59 +++++
 rtl/emu_ram_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/emu_scan_pkg.sv
// Shared types and constants for the emulator RAM scan sequencer.
// CRC constants are consumed only when EMU_SCAN_CRC_EN is defined.
package emu_scan_pkg;

  localparam int DATA_WIDTH_DEF = 64;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HALT_SETUP = 3'd1,
    S_DUMP       = 3'd2,
    S_DUMP_DRAIN = 3'd3,
    S_RESTORE    = 3'd4,
    S_REST_TAIL  = 3'd5,
    S_UNSCAN     = 3'd6,
    S_RELEASE    = 3'd7
  } scan_state_t;

  // Must be able to represent CHAIN_WORDS + SDO_LATENCY scan cycles.
  function automatic int cnt_width(input int chain_words, input int latency);
    return $clog2(chain_words + latency + 1);
  endfunction

endpackage

// File: rtl/emu_scan_skid_fifo.sv
// Small synchronous FIFO used as the dump-path skid buffer.
// Head word is presented combinationally and only moves on pop.
module emu_scan_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (cnt == CNTW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/emu_ram_scan_ctrl.sv
// Checkpoint sequencer between the DMA streams and the DUT RAM scan chain.
// Optional CRC-32 over handed-off words: define EMU_SCAN_CRC_EN.
module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CHAIN_WORDS = 64,
  parameter int SDO_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_dump,
  input  logic                            start_restore,
  output logic                            busy,
  output logic                            done,
  output logic                            halt,
  output logic                            ram_scan,
  output logic                            ram_dir,
  output logic [DATA_WIDTH-1:0]           ram_sdi,
  input  logic [DATA_WIDTH-1:0]           ram_sdo,
  output logic                            dump_valid,
  input  logic                            dump_ready,
  output logic [DATA_WIDTH-1:0]           dump_data,
  input  logic                            rest_valid,
  output logic                            rest_ready,
  input  logic [DATA_WIDTH-1:0]           rest_data,
  output logic [2:0]                      dbg_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] dbg_fifo_count
`ifdef EMU_SCAN_CRC_EN
  ,
  output logic [31:0]                     crc
`endif
);

  localparam int CW = cnt_width(CHAIN_WORDS, SDO_LATENCY);
  localparam logic [CW-1:0] DUMP_LAST  = CW'(CHAIN_WORDS + SDO_LATENCY - 1);
  localparam logic [CW-1:0] REST_LAST  = CW'(CHAIN_WORDS - 1);
  localparam logic [CW-1:0] WORDS      = CW'(CHAIN_WORDS);
  localparam logic [CW-1:0] PRIME      = CW'(SDO_LATENCY);
  localparam logic [CW-1:0] CREDITS    = CW'(FIFO_DEPTH);

  scan_state_t state;
  scan_state_t state_n;

  logic                   dir_q;
  logic [CW-1:0]          issued;
  logic [CW-1:0]          popped;
  logic [CW-1:0]          in_flight;
  logic [DATA_WIDTH-1:0]  sdi_q;
  logic [SDO_LATENCY-1:0] tag_q;
  logic                   tag_in;
  logic                   scan_c;
  logic                   sdi_load;
  logic                   accept;
  logic                   credit_ok;
  logic                   fifo_push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   dump_pop;

  // Both streams: a word transfers on a cycle where valid && ready are high at
  // the rising edge; a source holding valid keeps its data stable until then.
  assign accept     = (state == S_IDLE) && (start_dump || start_restore);
  assign in_flight  = issued - popped;
  assign credit_ok  = (in_flight < CREDITS);
  assign dump_valid = !fifo_empty;
  assign dump_pop   = dump_valid && dump_ready;
  assign fifo_push  = tag_q[SDO_LATENCY-1] && !fifo_full;
  // Priming scans only fill the RAM output pipe, so they are not tagged.
  assign tag_in     = scan_c && (state == S_DUMP) && (issued >= PRIME);

  always_comb begin
    state_n    = state;
    scan_c     = 1'b0;
    sdi_load   = 1'b0;
    rest_ready = 1'b0;
    case (state)
      S_IDLE:       if (accept) state_n = S_HALT_SETUP;
      S_HALT_SETUP: state_n = dir_q ? S_RESTORE : S_DUMP;
      S_DUMP: begin
        if (credit_ok) begin
          scan_c = 1'b1;
          if (issued == DUMP_LAST) state_n = S_DUMP_DRAIN;
        end
      end
      S_DUMP_DRAIN: if (popped == WORDS) state_n = S_UNSCAN;
      S_RESTORE: begin
        rest_ready = 1'b1;
        if (rest_valid) begin
          scan_c   = 1'b1;
          sdi_load = 1'b1;
          if (issued == REST_LAST) state_n = S_REST_TAIL;
        end
      end
      // Extra scan pushes the word still sitting in the RAM input stage.
      S_REST_TAIL:  begin
        scan_c  = 1'b1;
        state_n = S_UNSCAN;
      end
      S_UNSCAN:     state_n = S_RELEASE;
      S_RELEASE:    state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      dir_q  <= 1'b0;
      issued <= '0;
      popped <= '0;
      sdi_q  <= '0;
      tag_q  <= '0;
    end else begin
      state    <= state_n;
      tag_q[0] <= tag_in;
      for (int i = 1; i < SDO_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (sdi_load) sdi_q <= rest_data;
      if (accept) begin
        dir_q  <= !start_dump;
        issued <= '0;
        popped <= '0;
      end else begin
        if (scan_c)   issued <= issued + 1'b1;
        if (dump_pop) popped <= popped + 1'b1;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_RELEASE);
  assign halt      = (state != S_IDLE) && (state != S_RELEASE);
  assign ram_scan  = scan_c;
  assign ram_dir   = dir_q;
  assign ram_sdi   = sdi_load ? rest_data : sdi_q;
  assign dbg_state = state;

  emu_scan_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (ram_sdo),
    .pop       (dump_pop),
    .pop_data  (dump_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (dbg_fifo_count)
  );

`ifdef EMU_SCAN_CRC_EN
  // MSB-first CRC-32, no reflection, no final inversion.
  function automatic logic [31:0] crc_word(input logic [31:0] c,
                                           input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--)
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ CRC_POLY) : {r[30:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || accept)  crc <= CRC_INIT;
    else if (dump_pop)  crc <= crc_word(crc, dump_data);
    else if (sdi_load)  crc <= crc_word(crc, rest_data);
  end
`endif

endmodule
